// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver.
// Holds the default clock/baud constants, the receiver state encoding and
// a helper that derives the clocks-per-bit count.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int unsigned DEF_CLK_HZ = 100_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    // Below four clocks per bit the half-bit point collapses, so clamp.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        int unsigned c;
        c = clk_hz / baud;
        return (c < 4) ? 4 : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset; both flops load RST_VAL
//   d_i   - asynchronous input
//   q_o   - synchronized output (two clocks of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8 data bits, LSB first, one stop bit, mid-bit sampling.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit between D7 and
// stop, a PARITY state and the parity_err output.
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   usb_rx     - asynchronous serial line, idles high
//   data       - last byte received without error
//   valid      - one-cycle strobe: new byte on data
//   frame_err  - one-cycle strobe: stop bit sampled low
//   busy       - high whenever the receiver is not idle
//   parity_err - (macro only) one-cycle strobe: parity mismatch
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on an armed (seen-high) line
// ST_START  | counting to mid start bit; high there = glitch, back out
// ST_DATA   | sampling 8 data bits, one per bit period
// ST_PARITY | (macro only) sampling the even-parity bit
// ST_STOP   | sampling the stop bit, issuing the result strobe
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usb_rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CW  = $clog2(CPB) + 1;
    // Counter runs down to zero, so the loads are one less than the span.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CPB - 1);

    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    // Cleared by a framing error so a stuck-low line cannot retrigger.
    logic          armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          par_bad_q, par_bad_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (usb_rx),
        .q_o   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        armed_d   = armed_q | rx_s;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s && armed_q) begin
                    state_d   = ST_START;
                    cnt_d     = HALF_LOAD;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        cnt_d   = BIT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    par_bad_d = rx_s ^ (^shift_q);
                    cnt_d     = BIT_LOAD;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == '0) begin
                    // Leave at mid stop bit so a back-to-back start edge is caught.
                    state_d = ST_IDLE;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shift_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
